// File: rtl/add_seq_wide_pkg.sv
// Shared types and helpers for the word-serial wide adder/subtractor.
package add_seq_wide_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MAX_WORDS = 16;
  localparam int unsigned MAX_W     = WORD_W * MAX_WORDS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Extract 32-bit slice k (bits [32k+31:32k]) from a zero-extended wide vector.
  function automatic logic [WORD_W-1:0] get_slice(input logic [MAX_W-1:0] v,
                                                  input int unsigned     k);
    return v[k*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/add_seq_wide_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group carry.
module add_seq_wide_cla
  import add_seq_wide_pkg::*;
(
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic              i_cin,
  output logic [WORD_W-1:0] o_sum_c,
  output logic              o_cout_c
);

  localparam int unsigned NGRP = WORD_W / 4;

  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] p;
  logic [WORD_W:0]   c;

  // Per-group lookahead carries; group carry-out from group generate/propagate.
  always_comb begin
    g    = i_a & i_b;
    p    = i_a ^ i_b;
    c    = '0;
    c[0] = i_cin;
    for (int j = 0; j < NGRP; j++) begin
      c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
      c[4*j+4] = g[4*j+3] | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
    end
  end

  assign o_sum_c  = p ^ c[WORD_W-1:0];
  assign o_cout_c = c[WORD_W];

endmodule

// File: rtl/add_seq_wide.sv
// Word-serial wide add/sub: one 32-bit CLA reused per slice, LSW first,
// carry registered between slices.
module add_seq_wide
  import add_seq_wide_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 4
)
(
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [WORD_W*NUM_WORDS-1:0]   i_a,
  input  logic [WORD_W*NUM_WORDS-1:0]   i_b,
  input  logic                          i_cin,
  input  logic                          i_sub,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [WORD_W*NUM_WORDS-1:0]   o_s,
  output logic                          o_c,
  output logic                          o_ovf
);

  localparam int unsigned W     = WORD_W * NUM_WORDS;
  localparam int unsigned CNT_W = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      s_q, s_d;
  logic              c_q, c_d;
  logic              ovf_q, ovf_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;

  logic [WORD_W-1:0] slice_a_c;
  logic [WORD_W-1:0] slice_b_c;
  logic [WORD_W-1:0] sum_c;
  logic              cout_c;

  // Select the current operand slices for the shared adder.
  always_comb begin
    slice_a_c = get_slice(MAX_W'(a_q), 32'(cnt_q));
    slice_b_c = get_slice(MAX_W'(b_q), 32'(cnt_q));
  end

  add_seq_wide_cla u_cla (
    .i_a      (slice_a_c),
    .i_b      (slice_b_c),
    .i_cin    (carry_q),
    .o_sum_c  (sum_c),
    .o_cout_c (cout_c)
  );

  // Next-state and datapath update for accept, slice accumulation and handoff.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    s_d     = s_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    ready_d = ready_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          a_d     = i_a;
          b_d     = i_sub ? ~i_b : i_b;
          carry_d = i_sub ? 1'b1 : i_cin;
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        s_d[32'(cnt_q)*WORD_W +: WORD_W] = sum_c;
        carry_d = cout_c;
        cnt_d   = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == LAST_CNT) begin
          c_d     = cout_c;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_c[WORD_W-1] != a_q[W-1]);
          cnt_d   = '0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State, operand, result and handshake registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_s     = s_q;
  assign o_c     = c_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_add_seq_wide.sv
// Directed bench for add_seq_wide with a result scoreboard.
module tb_add_seq_wide;
  import add_seq_wide_pkg::*;

  localparam int unsigned NW = 4;
  localparam int unsigned W  = WORD_W * NW;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rstn;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_cin;
  logic         i_sub;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_s;
  logic         o_c;
  logic         o_ovf;

  int           checks;
  int           errors;
  exp_t         sb[$];
  logic [W-1:0] last_s;
  logic         last_c;
  logic         last_ovf;

  add_seq_wide #(.NUM_WORDS(NW)) dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .i_sub   (i_sub),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_s     (o_s),
    .o_c     (o_c),
    .o_ovf   (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: wide arithmetic, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [W:0]  full;
    if (sub) begin
      full  = {1'b0, a} - {1'b0, b};
      e.s   = full[W-1:0];
      e.c   = ~full[W];
      e.ovf = (a[W-1] != b[W-1]) && (e.s[W-1] != a[W-1]);
    end else begin
      full  = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      e.s   = full[W-1:0];
      e.c   = full[W];
      e.ovf = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        input int hold, input bit scramble);
    int   lat;
    bit   seen;
    exp_t e;
    @(negedge clk);
    i_a     = a;
    i_b     = b;
    i_cin   = cin;
    i_sub   = sub;
    i_valid = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (o_ready) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      check("accept_timeout", W'(0), W'(1));
      i_valid = 1'b0;
      return;
    end
    sb.push_back(model(a, b, cin, sub));
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (o_valid) seen = 1'b1;
      else begin
        if (scramble) begin
          i_a   = rnd_w();
          i_b   = rnd_w();
          i_sub = ~i_sub;
          i_cin = ~i_cin;
        end
        @(negedge clk);
        lat++;
      end
    end
    if (!seen) begin
      check("valid_timeout", W'(0), W'(1));
      void'(sb.pop_front());
      return;
    end
    check("latency", W'(lat), W'(NW + 1));
    check("ready_in_done", W'(o_ready), W'(0));
    e = sb.pop_front();
    check("result_s", o_s, e.s);
    check("result_c", W'(o_c), W'(e.c));
    check("result_ovf", W'(o_ovf), W'(e.ovf));
    last_s   = o_s;
    last_c   = o_c;
    last_ovf = o_ovf;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", W'(o_valid), W'(1));
      check("hold_ready", W'(o_ready), W'(0));
      check("hold_s", o_s, e.s);
      check("hold_c", W'(o_c), W'(e.c));
      check("hold_ovf", W'(o_ovf), W'(e.ovf));
    end
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    check("post_valid", W'(o_valid), W'(0));
    check("post_ready", W'(o_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] minmax;
    logic [W-1:0] msb;
    logic [W-1:0] neg2;
    checks   = 0;
    errors   = 0;
    rstn     = 1'b0;
    i_valid  = 1'b0;
    i_a      = '0;
    i_b      = '0;
    i_cin    = 1'b0;
    i_sub    = 1'b0;
    i_ready  = 1'b0;
    ones     = '1;
    minmax   = {1'b0, {(W-1){1'b1}}};
    msb      = {1'b1, {(W-1){1'b0}}};
    neg2     = ~W'(1);

    #12;
    check("rst_ready", W'(o_ready), W'(1));
    check("rst_valid", W'(o_valid), W'(0));
    check("rst_s", o_s, W'(0));
    check("rst_c", W'(o_c), W'(0));
    check("rst_ovf", W'(o_ovf), W'(0));
    @(negedge clk);
    rstn = 1'b1;

    run_op(W'(32'hFFFF_FFFF), W'(1), 1'b0, 1'b0, 0, 1'b0);
    check("tp_carry_slice_s", last_s, W'(64'h1_0000_0000));
    check("tp_carry_slice_c", W'(last_c), W'(0));

    run_op(ones, W'(0), 1'b1, 1'b0, 0, 1'b0);
    check("tp_ripple_s", last_s, W'(0));
    check("tp_ripple_c", W'(last_c), W'(1));
    check("tp_ripple_ovf", W'(last_ovf), W'(0));

    run_op(W'(5), W'(7), 1'b0, 1'b1, 0, 1'b0);
    check("tp_sub_neg_s", last_s, neg2);
    check("tp_sub_neg_c", W'(last_c), W'(0));
    check("tp_sub_neg_ovf", W'(last_ovf), W'(0));

    run_op(W'(7), W'(5), 1'b0, 1'b1, 0, 1'b0);
    check("tp_sub_pos_s", last_s, W'(2));
    check("tp_sub_pos_c", W'(last_c), W'(1));

    run_op(minmax, W'(1), 1'b0, 1'b0, 0, 1'b0);
    check("tp_add_ovf_s", last_s, msb);
    check("tp_add_ovf_ovf", W'(last_ovf), W'(1));
    check("tp_add_ovf_c", W'(last_c), W'(0));

    run_op(msb, W'(1), 1'b0, 1'b1, 0, 1'b0);
    check("tp_sub_ovf_s", last_s, minmax);
    check("tp_sub_ovf_ovf", W'(last_ovf), W'(1));

    run_op(rnd_w(), rnd_w(), 1'b1, 1'b0, 10, 1'b1);
    run_op(rnd_w(), rnd_w(), 1'b1, 1'b1, 3, 1'b1);
    run_op(rnd_w(), rnd_w(), 1'b0, 1'b0, 0, 1'b0);

    // Abort an operation in its second ADD cycle.
    @(negedge clk);
    i_a     = W'(1);
    i_b     = W'(1);
    i_cin   = 1'b0;
    i_sub   = 1'b0;
    i_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("abort_ready", W'(o_ready), W'(1));
    check("abort_valid", W'(o_valid), W'(0));
    check("abort_s", o_s, W'(0));
    check("abort_c", W'(o_c), W'(0));
    check("abort_ovf", W'(o_ovf), W'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("abort_no_result", W'(o_valid), W'(0));

    run_op(W'(3), W'(4), 1'b0, 1'b0, 0, 1'b0);
    check("after_abort_s", last_s, W'(7));

    check("sb_empty", W'(sb.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
